io_bus_bridge: RTL

Decodes the single-master IO port driven by the system bus (off-chip memory line fills/evictions and peripheral accesses) and routes each access to one of three slaves: SDRAM controller, UART, GPIO. Checks alignment, detects unmapped addresses and hung slaves, and returns one `io_ready` pulse per access. This gives the bus's edge-detecting burst loop a clean low-high-low handshake for every beat.

---
 rtl/io_bus_bridge_if.sv | 42 ++++
 rtl/io_bus_bridge.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/io_bus_bridge_if.sv
// IO port bundle between the system-bus master, the bridge and its three slaves.
// The "slave" modport is the bridge's view; "master" is the environment driving it.
interface io_bus_bridge_if;
  // Master-side IO port
  logic [31:0] io_addr;
  logic        io_read;
  logic        io_write;
  logic [31:0] io_wdata;
  logic [1:0]  io_byte_size;
  logic [31:0] io_rdata;
  logic        io_ready;
  logic        io_err;

  // Shared slave request fields and one-hot select
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [1:0]  s_byte_size;
  logic        s_we;
  logic [2:0]  s_req;

  // Per-slave responses: 0 = SDRAM, 1 = UART, 2 = GPIO
  logic [31:0] s0_rdata;
  logic [31:0] s1_rdata;
  logic [31:0] s2_rdata;
  logic        s0_ready;
  logic        s1_ready;
  logic        s2_ready;

  modport slave (
    input  io_addr, io_read, io_write, io_wdata, io_byte_size,
    output io_rdata, io_ready, io_err,
    output s_addr, s_wdata, s_byte_size, s_we, s_req,
    input  s0_rdata, s1_rdata, s2_rdata, s0_ready, s1_ready, s2_ready
  );

  modport master (
    output io_addr, io_read, io_write, io_wdata, io_byte_size,
    input  io_rdata, io_ready, io_err,
    input  s_addr, s_wdata, s_byte_size, s_we, s_req,
    output s0_rdata, s1_rdata, s2_rdata, s0_ready, s1_ready, s2_ready
  );
endinterface

// File: rtl/io_bus_bridge.sv
// IO bus bridge: decodes one master access, routes it to SDRAM/UART/GPIO, checks
// alignment and mapping, bounds slave wait time and returns one io_ready pulse
// per access followed by a mandatory low cycle.
module io_bus_bridge #(
  parameter logic [31:0] MEM_BASE    = 32'h8000_0000,
  parameter logic [31:0] MEM_MASK    = 32'hF000_0000,
  parameter logic [31:0] UART_BASE   = 32'h1000_0000,
  parameter logic [31:0] GPIO_BASE   = 32'h1000_1000,
  parameter logic [31:0] PERIPH_MASK = 32'hFFFF_F000,
  parameter int unsigned TIMEOUT     = 255
) (
  input logic           clk,
  input logic           rst,
  io_bus_bridge_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StGap} state_e;

  // Last counter value still inside the wait window; reaching it with no ready times out.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  s_req_q, s_req_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic [1:0]  s_size_q, s_size_d;
  logic        s_we_q, s_we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        mem_hit, uart_hit, gpio_hit;
  logic [2:0]  hit_sel;
  logic        misalign;
  logic        dec_err;
  logic        sel_ready;
  logic [31:0] sel_rdata;

  // Address window decode and alignment check on the live request.
  always_comb begin
    mem_hit  = (bus.io_addr & MEM_MASK) == (MEM_BASE & MEM_MASK);
    uart_hit = (bus.io_addr & PERIPH_MASK) == (UART_BASE & PERIPH_MASK);
    gpio_hit = (bus.io_addr & PERIPH_MASK) == (GPIO_BASE & PERIPH_MASK);
    hit_sel  = 3'b000;
    if (mem_hit) begin
      hit_sel = 3'b001;
    end else if (uart_hit) begin
      hit_sel = 3'b010;
    end else if (gpio_hit) begin
      hit_sel = 3'b100;
    end
    misalign = 1'b0;
    case (bus.io_byte_size)
      2'd0:    misalign = bus.io_addr[1:0] != 2'b00;
      2'd1:    misalign = bus.io_addr[0];
      2'd2:    misalign = 1'b0;
      default: misalign = 1'b1;
    endcase
    dec_err = (hit_sel == 3'b000) || misalign;
  end

  // Response of the selected slave only; other slaves' readies are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = 32'h0;
    unique case (s_req_q)
      3'b001: begin
        sel_ready = bus.s0_ready;
        sel_rdata = bus.s0_rdata;
      end
      3'b010: begin
        sel_ready = bus.s1_ready;
        sel_rdata = bus.s1_rdata;
      end
      3'b100: begin
        sel_ready = bus.s2_ready;
        sel_rdata = bus.s2_rdata;
      end
      default: begin
        sel_ready = 1'b0;
        sel_rdata = 32'h0;
      end
    endcase
  end

  // Next-state logic for the access FSM and its captured request/response.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    s_req_d   = s_req_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_size_d  = s_size_q;
    s_we_d    = s_we_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.io_read || bus.io_write) begin
          s_addr_d  = bus.io_addr;
          s_wdata_d = bus.io_wdata;
          s_size_d  = bus.io_byte_size;
          s_we_d    = bus.io_write;
          if (dec_err) begin
            state_d = StResp;
            err_d   = 1'b1;
            rdata_d = 32'h0;
            s_req_d = 3'b000;
          end else begin
            state_d = StReq;
            s_req_d = hit_sel;
            cnt_d   = 8'd0;
          end
        end
      end
      StReq: begin
        // A ready on the timeout edge still wins.
        if (sel_ready) begin
          state_d = StResp;
          err_d   = 1'b0;
          rdata_d = s_we_q ? 32'h0 : sel_rdata;
          s_req_d = 3'b000;
        end else if (cnt_q >= TimeoutLast) begin
          state_d = StResp;
          err_d   = 1'b1;
          rdata_d = 32'hDEAD_BEEF;
          s_req_d = 3'b000;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: begin
        state_d = StGap;
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      s_req_q   <= 3'b000;
      s_addr_q  <= 32'h0;
      s_wdata_q <= 32'h0;
      s_size_q  <= 2'd0;
      s_we_q    <= 1'b0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_req_q   <= s_req_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_size_q  <= s_size_d;
      s_we_q    <= s_we_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Outputs: io_err only qualifies the RESP pulse; io_rdata holds between accesses.
  always_comb begin
    bus.io_ready    = state_q == StResp;
    bus.io_err      = (state_q == StResp) && err_q;
    bus.io_rdata    = rdata_q;
    bus.s_req       = s_req_q;
    bus.s_addr      = s_addr_q;
    bus.s_wdata     = s_wdata_q;
    bus.s_byte_size = s_size_q;
    bus.s_we        = s_we_q;
  end

endmodule
